// File: rtl/dsm_pkg.sv
// Shared constants, types and the noise-cancellation helper for the MASH delta-sigma modulator.
package dsm_pkg;

    localparam int unsigned ORDER_MIN = 1;
    localparam int unsigned ORDER_MAX = 3;

    // Dither LFSR: x^15 + x^14 + 1, Fibonacci form shifting towards the MSB.
    localparam int unsigned LFSR_W    = 15;
    localparam logic [14:0] LFSR_TAPS = 15'h6000;
    localparam logic [14:0] LFSR_SEED = 15'h0001;

    // Sized for the default INT_W=4 (INT_W+3); y only spans -3..4, so it fits any INT_W.
    localparam int unsigned NCL_W = 7;
    typedef logic signed [NCL_W-1:0] ncl_t;

    // c    = {c3, c2, c1} for the current step
    // hist = {c3_d2, c3_d1, c2_d1} from previous enabled steps
    function automatic ncl_t ncl_sum(input logic [2:0] c, input logic [2:0] hist,
                                     input int unsigned order);
        ncl_t y;
        y = $signed({6'b000000, c[0]});
        if (order >= 2) begin
            y = y + $signed({6'b000000, c[1]}) - $signed({6'b000000, hist[0]});
        end
        if (order >= 3) begin
            y = y + $signed({6'b000000, c[2]}) - $signed({5'b00000, hist[1], 1'b0})
                  + $signed({6'b000000, hist[2]});
        end
        return y;
    endfunction

endpackage

// File: rtl/dsm_acc_stage.sv
// One MASH accumulator stage: modular FRAC_W-bit accumulator whose overflow is the carry.
// The sum and carry are combinational so stages chain within a single cycle.
module dsm_acc_stage #(
    parameter int unsigned FRAC_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [FRAC_W-1:0] i_din,
    input  logic              i_cin,
    output logic [FRAC_W-1:0] o_sum_lo,
    output logic              o_carry
);

    logic [FRAC_W-1:0] r_acc;
    logic [FRAC_W:0]   w_sum;

    assign w_sum    = {1'b0, r_acc} + {1'b0, i_din} + (FRAC_W+1)'(i_cin);
    assign o_sum_lo = w_sum[FRAC_W-1:0];
    assign o_carry  = w_sum[FRAC_W];

    // Accumulator advances only on enabled steps; wrap is intentional.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum[FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/mash_dsm.sv
// MASH 1-1-1 delta-sigma modulator with selectable order, registered config and saturation.
// Optional dither on the stage-1 carry-in is enabled by defining DSM_DITHER_EN.
module mash_dsm
    import dsm_pkg::*;
#(
    parameter int unsigned ORDER  = 3,
    parameter int unsigned FRAC_W = 16,
    parameter int unsigned INT_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_cfg_load,
    input  logic [INT_W-1:0]  i_in_i,
    input  logic [FRAC_W-1:0] i_in_f,
    output logic [INT_W-1:0]  o_out,
    output logic              o_out_vld,
    output logic              o_sat
);

    localparam int unsigned V_W = INT_W + 3;
    localparam logic signed [V_W-1:0] OUT_MAX = V_W'((1 << INT_W) - 1);

    if (ORDER < ORDER_MIN || ORDER > ORDER_MAX) begin : g_bad_order
        $error("mash_dsm: ORDER must be in 1..3");
    end

    logic [INT_W-1:0]  r_i_q;
    logic [FRAC_W-1:0] r_f_q;
    logic              r_c2_d1, r_c3_d1, r_c3_d2;
    logic [INT_W-1:0]  r_out;
    logic              r_vld, r_sat;

    logic [FRAC_W-1:0]     w_din [ORDER_MAX];
    logic [FRAC_W-1:0]     w_lo  [ORDER_MAX];
    logic [ORDER_MAX-1:0]  w_carry;
    logic                  w_cin;
    ncl_t                  w_y;
    logic signed [V_W-1:0] w_y_ext, w_v;
    logic [INT_W-1:0]      w_out_d;
    logic                  w_sat_d;

`ifdef DSM_DITHER_EN
    logic [LFSR_W-1:0] r_lfsr;

    // Dither sequence advances once per enabled step.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign w_cin = r_lfsr[0];
`else
    assign w_cin = 1'b0;
`endif

    assign w_din[0] = r_f_q;

    for (genvar g = 0; g < ORDER_MAX; g++) begin : g_stage
        if (g > 0) begin : g_chain
            assign w_din[g] = w_lo[g-1];
        end
        if (g < ORDER) begin : g_on
            dsm_acc_stage #(
                .FRAC_W (FRAC_W)
            ) u_stage (
                .i_clk    (i_clk),
                .i_rst    (i_rst),
                .i_en     (i_en),
                .i_din    (w_din[g]),
                .i_cin    ((g == 0) ? w_cin : 1'b0),
                .o_sum_lo (w_lo[g]),
                .o_carry  (w_carry[g])
            );
        end else begin : g_off
            assign w_lo[g]    = '0;
            assign w_carry[g] = 1'b0;
        end
    end

    assign w_y     = ncl_sum(w_carry, {r_c3_d2, r_c3_d1, r_c2_d1}, ORDER);
    assign w_y_ext = V_W'(w_y);
    assign w_v     = $signed({3'b000, r_i_q}) + w_y_ext;

    // Clamp the corrected value into the unsigned output range.
    always_comb begin
        w_out_d = w_v[INT_W-1:0];
        w_sat_d = 1'b0;
        if (w_v < 0) begin
            w_out_d = '0;
            w_sat_d = 1'b1;
        end else if (w_v > OUT_MAX) begin
            w_out_d = '1;
            w_sat_d = 1'b1;
        end
    end

    // Config capture, carry history and registered output; en low holds everything but flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_i_q   <= '0;
            r_f_q   <= '0;
            r_c2_d1 <= 1'b0;
            r_c3_d1 <= 1'b0;
            r_c3_d2 <= 1'b0;
            r_out   <= '0;
            r_vld   <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            // Accumulators are left alone on reload to keep phase continuity.
            if (i_cfg_load) begin
                r_i_q <= i_in_i;
                r_f_q <= i_in_f;
            end
            if (i_en) begin
                r_c2_d1 <= w_carry[1];
                r_c3_d1 <= w_carry[2];
                r_c3_d2 <= r_c3_d1;
                r_out   <= w_out_d;
                r_sat   <= w_sat_d;
                r_vld   <= 1'b1;
            end else begin
                r_vld <= 1'b0;
                r_sat <= 1'b0;
            end
        end
    end

    assign o_out     = r_out;
    assign o_out_vld = r_vld;
    assign o_sat     = r_sat;

endmodule

// File: tb/tb_mash_dsm.sv
// Self-checking bench for mash_dsm: ORDER=3 and ORDER=1 instances share stimulus and are
// checked against a behavioural model through an expectation queue.
module tb_mash_dsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0, en = 1'b0, cfg = 1'b0;
    logic [3:0]  in_i = '0;
    logic [15:0] in_f = '0;
    logic [3:0]  out3, out1;
    logic        vld3, vld1, sat3, sat1;

    always #5 clk = ~clk;

    mash_dsm #(.ORDER(3), .FRAC_W(16), .INT_W(4)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_cfg_load(cfg), .i_in_i(in_i), .i_in_f(in_f),
        .o_out(out3), .o_out_vld(vld3), .o_sat(sat3)
    );

    mash_dsm #(.ORDER(1), .FRAC_W(16), .INT_W(4)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_cfg_load(cfg), .i_in_i(in_i), .i_in_f(in_f),
        .o_out(out1), .o_out_vld(vld1), .o_sat(sat1)
    );

    typedef struct {
        int acc1, acc2, acc3;
        int c2d1, c3d1, c3d2;
        int iq, fq;
        int out;
        bit vld, sat;
    } mstate_t;

    typedef struct {
        logic [3:0] o3; logic v3, s3;
        logic [3:0] o1; logic v1, s1;
    } exp_t;

    mstate_t m [2];  // [0]: ORDER=3, [1]: ORDER=1
    exp_t    sb [$];
    int      n_cmp = 0, n_err = 0;
    int      gap_ref [12];

    // Behavioural MASH step for one instance, using the inputs currently driven.
    task automatic model_step(input int k, input int order);
        int s1, s2, s3, c1, c2, c3, y, v;
        if (rst) begin
            m[k] = '{default: 0};
            return;
        end
        if (en) begin
            s1 = m[k].acc1 + m[k].fq; c1 = s1 >> 16; m[k].acc1 = s1 & 'hFFFF;
            y = c1;
            if (order >= 2) begin
                s2 = m[k].acc2 + m[k].acc1; c2 = s2 >> 16; m[k].acc2 = s2 & 'hFFFF;
                y = y + c2 - m[k].c2d1;
                m[k].c2d1 = c2;
            end
            if (order >= 3) begin
                s3 = m[k].acc3 + m[k].acc2; c3 = s3 >> 16; m[k].acc3 = s3 & 'hFFFF;
                y = y + c3 - 2 * m[k].c3d1 + m[k].c3d2;
                m[k].c3d2 = m[k].c3d1;
                m[k].c3d1 = c3;
            end
            v = m[k].iq + y;
            if (v < 0) begin
                m[k].out = 0; m[k].sat = 1'b1;
            end else if (v > 15) begin
                m[k].out = 15; m[k].sat = 1'b1;
            end else begin
                m[k].out = v; m[k].sat = 1'b0;
            end
            m[k].vld = 1'b1;
        end else begin
            m[k].vld = 1'b0;
            m[k].sat = 1'b0;
        end
        if (cfg) begin
            m[k].iq = int'(in_i);
            m[k].fq = int'(in_f);
        end
    endtask

    // Apply one cycle of stimulus, queue the model's expectation, sample #1 after the edge.
    task automatic drive(input logic r, input logic e, input logic c,
                         input logic [3:0] ii, input logic [15:0] ff);
        exp_t x;
        rst = r; en = e; cfg = c; in_i = ii; in_f = ff;
        model_step(0, 3);
        model_step(1, 1);
        x.o3 = m[0].out[3:0]; x.v3 = m[0].vld; x.s3 = m[0].sat;
        x.o1 = m[1].out[3:0]; x.v1 = m[1].vld; x.s1 = m[1].sat;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t x;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 4'd9, 16'h1234);
            x = sb.pop_front(); n_cmp++;
            if ({out3, vld3, sat3, out1, vld1, sat1} !== {x.o3, x.v3, x.s3, x.o1, x.v1, x.s1}) begin
                n_err++;
                $display("FAIL sb_reset step %0d: got %0d/%b/%b %0d/%b/%b want %0d/%b/%b %0d/%b/%b",
                         i, out3, vld3, sat3, out1, vld1, sat1, x.o3, x.v3, x.s3, x.o1, x.v1, x.s1);
            end
            n_cmp++;
            if ({out3, vld3, sat3, out1, vld1, sat1} !== 12'b0) begin
                n_err++;
                $display("FAIL reset_zero step %0d: got %0d/%b/%b %0d/%b/%b want all 0",
                         i, out3, vld3, sat3, out1, vld1, sat1);
            end
        end
    endtask

    task automatic test_dc();
        exp_t x;
        int bad = 0;
        for (int i = 0; i < 102; i++) begin
            if (i == 0)      drive(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
            else if (i == 1) drive(1'b0, 1'b0, 1'b1, 4'd7, 16'h0);
            else             drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0);
            x = sb.pop_front(); n_cmp++;
            if ({out3, vld3, sat3, out1, vld1, sat1} !== {x.o3, x.v3, x.s3, x.o1, x.v1, x.s1}) begin
                n_err++;
                $display("FAIL sb_dc step %0d: got %0d/%b/%b %0d/%b/%b want %0d/%b/%b %0d/%b/%b",
                         i, out3, vld3, sat3, out1, vld1, sat1, x.o3, x.v3, x.s3, x.o1, x.v1, x.s1);
            end
            if (i >= 2 && {out3, vld3, sat3, out1} !== {4'd7, 1'b1, 1'b0, 4'd7}) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL dc_constant: got %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_order1_half();
        exp_t x;
        int sum1 = 0;
        for (int i = 0; i < 1026; i++) begin
            if (i == 0)      drive(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
            else if (i == 1) drive(1'b0, 1'b0, 1'b1, 4'd5, 16'h8000);
            else             drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0);
            x = sb.pop_front(); n_cmp++;
            if ({out3, vld3, sat3, out1, vld1, sat1} !== {x.o3, x.v3, x.s3, x.o1, x.v1, x.s1}) begin
                n_err++;
                $display("FAIL sb_order1 step %0d: got %0d/%b/%b %0d/%b/%b want %0d/%b/%b %0d/%b/%b",
                         i, out3, vld3, sat3, out1, vld1, sat1, x.o3, x.v3, x.s3, x.o1, x.v1, x.s1);
            end
            if (i >= 2) sum1 += int'(out1);
            if (i == 2 || i == 3) begin
                n_cmp++;
                if (out1 !== ((i == 2) ? 4'd5 : 4'd6)) begin
                    n_err++;
                    $display("FAIL order1_first step %0d: got %0d want %0d", i - 1, out1,
                             (i == 2) ? 5 : 6);
                end
            end
        end
        n_cmp++;
        if (sum1 != 5632) begin
            n_err++;
            $display("FAIL order1_sum: got %0d want 5632", sum1);
        end
    endtask

    task automatic test_order3_long();
        exp_t x;
        int sum3 = 0, sum1 = 0, bad = 0;
        for (int i = 0; i < 65538; i++) begin
            if (i == 0)      drive(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
            else if (i == 1) drive(1'b0, 1'b0, 1'b1, 4'd7, 16'h4000);
            else             drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0);
            x = sb.pop_front(); n_cmp++;
            if ({out3, vld3, sat3, out1, vld1, sat1} !== {x.o3, x.v3, x.s3, x.o1, x.v1, x.s1}) begin
                n_err++;
                $display("FAIL sb_order3 step %0d: got %0d/%b/%b %0d/%b/%b want %0d/%b/%b %0d/%b/%b",
                         i, out3, vld3, sat3, out1, vld1, sat1, x.o3, x.v3, x.s3, x.o1, x.v1, x.s1);
            end
            if (i >= 2) begin
                sum3 += int'(out3);
                sum1 += int'(out1);
                if (out3 < 4'd4 || out3 > 4'd11 || sat3 !== 1'b0) bad++;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL order3_range: got %0d out-of-range/sat cycles want 0", bad);
        end
        n_cmp++;
        if (sum3 != 475136) begin
            n_err++;
            $display("FAIL order3_sum: got %0d want 475136", sum3);
        end
        n_cmp++;
        if (sum1 != 475136) begin
            n_err++;
            $display("FAIL order1_long_sum: got %0d want 475136", sum1);
        end
    endtask

    task automatic test_saturation();
        exp_t x;
        int hi_dut = 0, hi_mdl = 0, lo_dut = 0, lo_mdl = 0, bad = 0;
        for (int i = 0; i < 402; i++) begin
            if (i == 0)        drive(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
            else if (i == 1)   drive(1'b0, 1'b0, 1'b1, 4'd15, 16'hFFFF);
            else if (i == 202) drive(1'b0, 1'b1, 1'b1, 4'd0, 16'h4000);
            else               drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0);
            x = sb.pop_front(); n_cmp++;
            if ({out3, vld3, sat3, out1, vld1, sat1} !== {x.o3, x.v3, x.s3, x.o1, x.v1, x.s1}) begin
                n_err++;
                $display("FAIL sb_sat step %0d: got %0d/%b/%b %0d/%b/%b want %0d/%b/%b %0d/%b/%b",
                         i, out3, vld3, sat3, out1, vld1, sat1, x.o3, x.v3, x.s3, x.o1, x.v1, x.s1);
            end
            // Step 202 still uses the old (15) config.
            if (i <= 202) begin
                hi_dut += int'(sat3); hi_mdl += int'(x.s3);
                if (sat3 === 1'b1 && out3 !== 4'd15) bad++;
            end else begin
                lo_dut += int'(sat3); lo_mdl += int'(x.s3);
                if (sat3 === 1'b1 && out3 !== 4'd0) bad++;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL sat_clamp_value: got %0d wrong clamps want 0", bad);
        end
        n_cmp++;
        if (hi_dut != hi_mdl || hi_mdl == 0) begin
            n_err++;
            $display("FAIL sat_high_count: got %0d want %0d (nonzero)", hi_dut, hi_mdl);
        end
        n_cmp++;
        if (lo_dut != lo_mdl) begin
            n_err++;
            $display("FAIL sat_low_count: got %0d want %0d", lo_dut, lo_mdl);
        end
    endtask

    task automatic test_en_gap();
        exp_t x;
        int got [12];
        int k = 0, bad = 0;
        logic [3:0] p3, p1;
        // Gap-free reference run.
        for (int i = 0; i < 14; i++) begin
            if (i == 0)      drive(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
            else if (i == 1) drive(1'b0, 1'b0, 1'b1, 4'd3, 16'h1234);
            else             drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0);
            x = sb.pop_front(); n_cmp++;
            if ({out3, vld3, sat3, out1, vld1, sat1} !== {x.o3, x.v3, x.s3, x.o1, x.v1, x.s1}) begin
                n_err++;
                $display("FAIL sb_gapref step %0d: got %0d/%b/%b %0d/%b/%b want %0d/%b/%b %0d/%b/%b",
                         i, out3, vld3, sat3, out1, vld1, sat1, x.o3, x.v3, x.s3, x.o1, x.v1, x.s1);
            end
            if (i >= 2) gap_ref[i-2] = int'(out3);
        end
        // Same run with en pattern ...1,0,0,1...
        p3 = '0; p1 = '0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0)                drive(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
            else if (i == 1)           drive(1'b0, 1'b0, 1'b1, 4'd3, 16'h1234);
            else if (i == 7 || i == 8) drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
            else                       drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0);
            x = sb.pop_front(); n_cmp++;
            if ({out3, vld3, sat3, out1, vld1, sat1} !== {x.o3, x.v3, x.s3, x.o1, x.v1, x.s1}) begin
                n_err++;
                $display("FAIL sb_gap step %0d: got %0d/%b/%b %0d/%b/%b want %0d/%b/%b %0d/%b/%b",
                         i, out3, vld3, sat3, out1, vld1, sat1, x.o3, x.v3, x.s3, x.o1, x.v1, x.s1);
            end
            if (i == 7 || i == 8) begin
                if ({vld3, sat3, vld1, sat1} !== 4'b0 || out3 !== p3 || out1 !== p1) bad++;
            end else if (i >= 2 && vld3 === 1'b1 && k < 12) begin
                got[k] = int'(out3);
                k++;
            end
            p3 = out3; p1 = out1;
        end
        n_cmp++;
        if (bad != 0 || k != 12) begin
            n_err++;
            $display("FAIL gap_hold: got %0d bad idle cycles, %0d valid outputs want 0, 12", bad, k);
        end
        for (int j = 0; j < 12; j++) begin
            n_cmp++;
            if (j < k && got[j] != gap_ref[j]) begin
                n_err++;
                $display("FAIL gap_seq idx %0d: got %0d want %0d", j, got[j], gap_ref[j]);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t x;
        for (int i = 0; i < 25; i++) begin
            if (i == 0)       drive(1'b0, 1'b1, 1'b1, 4'd9, 16'h2222);
            else if (i == 11) drive(1'b1, 1'b1, 1'b0, 4'd0, 16'h0);
            else if (i == 12) drive(1'b0, 1'b0, 1'b1, 4'd3, 16'h1234);
            else              drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0);
            x = sb.pop_front(); n_cmp++;
            if ({out3, vld3, sat3, out1, vld1, sat1} !== {x.o3, x.v3, x.s3, x.o1, x.v1, x.s1}) begin
                n_err++;
                $display("FAIL sb_rstmid step %0d: got %0d/%b/%b %0d/%b/%b want %0d/%b/%b %0d/%b/%b",
                         i, out3, vld3, sat3, out1, vld1, sat1, x.o3, x.v3, x.s3, x.o1, x.v1, x.s1);
            end
            if (i == 11) begin
                n_cmp++;
                if ({out3, vld3, sat3, out1, vld1, sat1} !== 12'b0) begin
                    n_err++;
                    $display("FAIL rstmid_zero: got %0d/%b/%b %0d/%b/%b want all 0",
                             out3, vld3, sat3, out1, vld1, sat1);
                end
            end
            if (i >= 13) begin
                n_cmp++;
                if (int'(out3) != gap_ref[i-13]) begin
                    n_err++;
                    $display("FAIL rstmid_restart idx %0d: got %0d want %0d", i - 13, out3,
                             gap_ref[i-13]);
                end
            end
        end
    endtask

    task automatic test_cfg_same_cycle();
        exp_t x;
        for (int i = 0; i < 3; i++) begin
            if (i == 0)      drive(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
            else if (i == 1) drive(1'b0, 1'b1, 1'b1, 4'd9, 16'h0);
            else             drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0);
            x = sb.pop_front(); n_cmp++;
            if ({out3, vld3, sat3, out1, vld1, sat1} !== {x.o3, x.v3, x.s3, x.o1, x.v1, x.s1}) begin
                n_err++;
                $display("FAIL sb_cfgsame step %0d: got %0d/%b/%b %0d/%b/%b want %0d/%b/%b %0d/%b/%b",
                         i, out3, vld3, sat3, out1, vld1, sat1, x.o3, x.v3, x.s3, x.o1, x.v1, x.s1);
            end
            if (i >= 1) begin
                n_cmp++;
                if ({out3, vld3, out1} !== {((i == 1) ? 4'd0 : 4'd9), 1'b1,
                                            ((i == 1) ? 4'd0 : 4'd9)}) begin
                    n_err++;
                    $display("FAIL cfg_same_cycle step %0d: got o3=%0d v3=%b o1=%0d want %0d/1/%0d",
                             i, out3, vld3, out1, (i == 1) ? 0 : 9, (i == 1) ? 0 : 9);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_dc();
        test_order1_half();
        test_order3_long();
        test_saturation();
        test_en_gap();
        test_reset_mid();
        test_cfg_same_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
